// File: rtl/pc_stack_unit_if.sv
// pc_stack_unit_if
//   Bundles the fetch-sequencer control and status signals of pc_stack_unit.
//   The master side (the issuer: test bench or decode stage) drives the
//   program-start request, stall, CMP flags and the decoded branch fields.
//   The slave side (pc_stack_unit) returns the fetch address and status.
//
//   start, start_addr      : load a new program start address
//   stall                  : hold all sequencer state this cycle
//   EQ, LT, GT             : CMP flags used by the branch condition
//   cond_sel, op           : branch condition and operation
//   target, rel_offset     : ABS/CALL destination and signed REL offset
//   current_pc, halted     : fetch address and stopped status
//   stack_depth            : number of valid return entries
//   stack_overflow/underflow : sticky return-stack error flags
interface pc_stack_unit_if #(
  parameter int PC_WIDTH     = 12,
  parameter int OFFSET_WIDTH = 4,
  parameter int STACK_DEPTH  = 4
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

  logic                    start;
  logic [PC_WIDTH-1:0]     start_addr;
  logic                    stall;
  logic                    EQ;
  logic                    LT;
  logic                    GT;
  logic [2:0]              cond_sel;
  logic [2:0]              op;
  logic [PC_WIDTH-1:0]     target;
  logic [OFFSET_WIDTH-1:0] rel_offset;
  logic [PC_WIDTH-1:0]     current_pc;
  logic                    halted;
  logic [DEPTH_W-1:0]      stack_depth;
  logic                    stack_overflow;
  logic                    stack_underflow;

  // Issuer view: drives requests, observes status.
  modport master (
    output start, start_addr, stall, EQ, LT, GT, cond_sel, op, target, rel_offset,
    input  current_pc, halted, stack_depth, stack_overflow, stack_underflow
  );

  // Sequencer view: consumes requests, produces status.
  modport slave (
    input  start, start_addr, stall, EQ, LT, GT, cond_sel, op, target, rel_offset,
    output current_pc, halted, stack_depth, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/pc_stack_unit.sv
// pc_stack_unit
//   Fetch-stage program counter with a hardware return-address stack.
//   Supports sequential fetch, absolute and signed relative branches gated
//   by a CMP-flag condition, CALL/RET through a LIFO stack, HALT, and a
//   loadable program start address. All outputs are registered and change
//   together on the rising clock edge.
//
//   clk    : clock
//   reset  : synchronous active-high reset
//   bus    : pc_stack_unit_if slave port (requests in, status out)
module pc_stack_unit #(
  parameter int PC_WIDTH     = 12,
  parameter int OFFSET_WIDTH = 4,
  parameter int STACK_DEPTH  = 4
) (
  input  logic clk,
  input  logic reset,
  pc_stack_unit_if.slave bus
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

  localparam logic [2:0] OP_SEQ  = 3'b000;
  localparam logic [2:0] OP_ABS  = 3'b001;
  localparam logic [2:0] OP_REL  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];

  logic                take;
  logic                push_en;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] rel_ext;
  logic [IDX_W-1:0]    push_idx;
  logic [IDX_W-1:0]    top_idx;

  assign pc_inc   = pc_q + 1'b1;
  // A size cast of a signed value sign-extends, which also works when the
  // offset is already as wide as the PC.
  assign rel_ext  = PC_WIDTH'($signed(bus.rel_offset));
  assign push_idx = IDX_W'(depth_q);
  assign top_idx  = IDX_W'(depth_q - 1'b1);

  // Decode the branch condition from the CMP flags. The two "or equal"
  // forms let a single compare serve <= and >= branches.
  always_comb begin
    take = 1'b0;
    case (bus.cond_sel)
      3'b000:  take = 1'b0;
      3'b001:  take = bus.EQ;
      3'b010:  take = bus.LT;
      3'b011:  take = bus.GT;
      3'b100:  take = 1'b1;
      3'b101:  take = ~bus.EQ;
      3'b110:  take = bus.LT | bus.EQ;
      default: take = bus.GT | bus.EQ;
    endcase
  end

  // Next-state logic. Start outranks the halted hold, which outranks stall,
  // which outranks the op. A not-taken branch of any kind degrades to a
  // plain sequential step; CALL/RET errors freeze the PC and the stack.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;

    if (bus.start) begin
      state_d = ST_RUN;
      pc_d    = bus.start_addr;
      depth_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (state_q == ST_HALTED) begin
      state_d = ST_HALTED;
    end else if (!bus.stall) begin
      pc_d = pc_inc;
      case (bus.op)
        OP_ABS: begin
          if (take) pc_d = bus.target;
        end
        OP_REL: begin
          if (take) pc_d = pc_q + rel_ext;
        end
        OP_CALL: begin
          if (take) begin
            if (depth_q == DEPTH_FULL) begin
              ovf_d   = 1'b1;
              state_d = ST_HALTED;
              pc_d    = pc_q;
            end else begin
              push_en = 1'b1;
              depth_d = depth_q + 1'b1;
              pc_d    = bus.target;
            end
          end
        end
        OP_RET: begin
          if (take) begin
            if (depth_q == '0) begin
              unf_d   = 1'b1;
              state_d = ST_HALTED;
              pc_d    = pc_q;
            end else begin
              depth_d = depth_q - 1'b1;
              pc_d    = stack_mem[top_idx];
            end
          end
        end
        OP_HALT: begin
          state_d = ST_HALTED;
          pc_d    = pc_q;
        end
        default: pc_d = pc_inc;
      endcase
    end
  end

  // Sequencer state register; reset wins over everything computed above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-address storage. Entries are never cleared; depth alone says
  // which are valid. The push is suppressed when reset lands on a CALL.
  always_ff @(posedge clk) begin
    if (push_en && !reset) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

  assign bus.current_pc      = pc_q;
  assign bus.halted          = (state_q == ST_HALTED);
  assign bus.stack_depth     = depth_q;
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit
//   Self-checking bench for pc_stack_unit. Directed sequences walk the
//   documented scenarios, then randomized traffic runs against a behavioural
//   model that keeps the PC as an integer and the return stack as a queue.
module tb_pc_stack_unit;

  localparam int PC_WIDTH     = 12;
  localparam int OFFSET_WIDTH = 4;
  localparam int STACK_DEPTH  = 4;
  localparam int PC_MOD       = 1 << PC_WIDTH;
  localparam int OFF_MOD      = 1 << OFFSET_WIDTH;

  logic clk;
  logic reset;

  pc_stack_unit_if #(
    .PC_WIDTH(PC_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH), .STACK_DEPTH(STACK_DEPTH)
  ) bus ();

  pc_stack_unit #(
    .PC_WIDTH(PC_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH), .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;

  // Stimulus for the next cycle.
  bit s_rst, s_start, s_stall, s_eq, s_lt, s_gt;
  int s_addr, s_cond, s_op, s_tgt, s_rel;

  // Reference model state.
  int m_pc;
  bit m_halt, m_ovf, m_unf;
  int m_stack[$];

  // Compare one observed value with its expectation.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed == expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Branch condition as the architecture defines it.
  function automatic bit condMet(input int cond, input bit eq, input bit lt, input bit gt);
    case (cond)
      0: return 1'b0;
      1: return eq;
      2: return lt;
      3: return gt;
      4: return 1'b1;
      5: return !eq;
      6: return lt || eq;
      default: return gt || eq;
    endcase
  endfunction

  // Advance the model one clock using the stimulus just applied.
  task automatic modelStep();
    bit take;
    int off;
    int nxt;
    nxt = (m_pc + 1) % PC_MOD;
    if (s_rst) begin
      m_pc = 0; m_halt = 0; m_ovf = 0; m_unf = 0; m_stack.delete();
    end else if (s_start) begin
      m_pc = s_addr; m_halt = 0; m_ovf = 0; m_unf = 0; m_stack.delete();
    end else if (!m_halt && !s_stall) begin
      take = condMet(s_cond, s_eq, s_lt, s_gt);
      case (s_op)
        1: m_pc = take ? s_tgt : nxt;
        2: begin
          off  = (s_rel >= OFF_MOD / 2) ? s_rel - OFF_MOD : s_rel;
          m_pc = take ? (m_pc + off + PC_MOD) % PC_MOD : nxt;
        end
        3: begin
          if (!take) m_pc = nxt;
          else if (m_stack.size() == STACK_DEPTH) begin m_ovf = 1; m_halt = 1; end
          else begin m_stack.push_back(nxt); m_pc = s_tgt; end
        end
        4: begin
          if (!take) m_pc = nxt;
          else if (m_stack.size() == 0) begin m_unf = 1; m_halt = 1; end
          else m_pc = m_stack.pop_back();
        end
        5: m_halt = 1;
        default: m_pc = nxt;
      endcase
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, clock it in, update the
  // model, then compare every output shortly after the rising edge.
  task automatic applyStimulus();
    @(negedge clk);
    reset          = s_rst;
    bus.start      = s_start;
    bus.start_addr = PC_WIDTH'(s_addr);
    bus.stall      = s_stall;
    bus.EQ         = s_eq;
    bus.LT         = s_lt;
    bus.GT         = s_gt;
    bus.cond_sel   = 3'(s_cond);
    bus.op         = 3'(s_op);
    bus.target     = PC_WIDTH'(s_tgt);
    bus.rel_offset = OFFSET_WIDTH'(s_rel);
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("pc",        int'(bus.current_pc),      m_pc);
    checkOutput("halted",    int'(bus.halted),          int'(m_halt));
    checkOutput("depth",     int'(bus.stack_depth),     m_stack.size());
    checkOutput("overflow",  int'(bus.stack_overflow),  int'(m_ovf));
    checkOutput("underflow", int'(bus.stack_underflow), int'(m_unf));
  endtask

  // Helpers for the directed sequences.
  task automatic doOp(input int op, input int cond, input int tgt, input int rel,
                      input bit eq = 0, input bit lt = 0, input bit gt = 0, input bit stl = 0);
    s_rst = 0; s_start = 0; s_stall = stl;
    s_eq = eq; s_lt = lt; s_gt = gt;
    s_op = op; s_cond = cond; s_tgt = tgt; s_rel = rel; s_addr = 0;
    applyStimulus();
  endtask

  task automatic doStart(input int addr);
    s_rst = 0; s_start = 1; s_stall = 0; s_addr = addr;
    s_op = 5; s_cond = 4; s_tgt = 0; s_rel = 0;
    applyStimulus();
  endtask

  task automatic doReset();
    s_rst = 1; s_start = 0; s_stall = 0; s_op = 3; s_cond = 4; s_tgt = 'h123;
    applyStimulus();
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.start_addr = '0; bus.stall = 0;
    bus.EQ = 0; bus.LT = 0; bus.GT = 0; bus.cond_sel = '0; bus.op = '0;
    bus.target = '0; bus.rel_offset = '0;

    // Reset then sequential fetch.
    doReset();
    checkOutput("reset_pc", int'(bus.current_pc), 0);
    for (int i = 0; i < 5; i++) doOp(0, 0, 0, 0);
    checkOutput("seq_pc", int'(bus.current_pc), 5);

    // Start held two cycles, then backward REL.
    doStart('h100);
    doStart('h100);
    checkOutput("start_pc", int'(bus.current_pc), 'h100);
    doOp(2, 4, 0, 4'b1110);
    checkOutput("rel_back", int'(bus.current_pc), 'h0FE);
    doStart('hFFC);
    doOp(2, 4, 0, 7);
    checkOutput("rel_wrap", int'(bus.current_pc), 'h003);

    // Condition decode.
    doOp(1, 6, 'h020, 0, 0, 1, 0);
    checkOutput("cond_le", int'(bus.current_pc), 'h020);
    doOp(1, 5, 'h777, 0, 1, 0, 0);
    checkOutput("cond_ne", int'(bus.current_pc), 'h021);
    doOp(3, 0, 'h555, 0);
    checkOutput("call_nt_pc", int'(bus.current_pc), 'h022);

    // Nested CALL/RET.
    doStart('h010);
    doOp(3, 4, 'h200, 0);
    doOp(3, 4, 'h300, 0);
    checkOutput("call2_depth", int'(bus.stack_depth), 2);
    doOp(4, 4, 0, 0);
    checkOutput("ret1_pc", int'(bus.current_pc), 'h201);
    doOp(4, 4, 0, 0);
    checkOutput("ret2_pc", int'(bus.current_pc), 'h011);

    // Overflow on the fifth CALL, then ignored ops, then start recovery.
    doStart('h050);
    for (int i = 0; i < 5; i++) doOp(3, 4, 'h400 + 16 * i, 0);
    checkOutput("ovf_flag", int'(bus.stack_overflow), 1);
    checkOutput("ovf_pc", int'(bus.current_pc), 'h430);
    doOp(1, 4, 'h999, 0);
    checkOutput("ovf_hold", int'(bus.current_pc), 'h430);
    doStart('h060);
    checkOutput("ovf_clear", int'(bus.stack_overflow), 0);
    doOp(4, 4, 0, 0);
    checkOutput("unf_flag", int'(bus.stack_underflow), 1);

    // HALT with stall toggling, then reset mid-halt.
    doStart('h041);
    doOp(0, 0, 0, 0);
    doOp(5, 0, 0, 0);
    for (int i = 0; i < 4; i++) doOp(1, 4, 'h7FF, 0, 0, 0, 0, bit'(i % 2));
    checkOutput("halt_pc", int'(bus.current_pc), 'h042);
    doReset();
    checkOutput("halt_reset", int'(bus.halted), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      s_rst   = ($urandom_range(0, 99) == 0);
      s_start = ($urandom_range(0, 24) == 0);
      s_stall = ($urandom_range(0, 7) == 0);
      s_addr  = $urandom_range(0, PC_MOD - 1);
      s_eq    = $urandom_range(0, 1);
      s_lt    = $urandom_range(0, 1);
      s_gt    = $urandom_range(0, 1);
      s_cond  = $urandom_range(0, 7);
      s_op    = ($urandom_range(0, 3) == 0) ? 3 : $urandom_range(0, 7);
      s_tgt   = $urandom_range(0, PC_MOD - 1);
      s_rel   = $urandom_range(0, OFF_MOD - 1);
      applyStimulus();
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
